regfile_2w4r: RTL and testbench
===============================

REGFILE_2W4R -- requirements
Module: regfile_2w4r

Interface
REQ-001 Module SHALL have no parameters; widths come from the shared defines (`WS_TO_RF_BUS_WD = 76).
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 ws_to_rf_bus  input  76  dual write request from writeback: [75] we1, [74:70] waddr1, [69:38] wdata1, [37] we2, [36:32] waddr2, [31:0] wdata2.
REQ-005 raddr1..raddr4  input  5 each  read addresses (decode slot 1: src1/src2; slot 2: src1/src2).
REQ-006 rdata1..rdata4  output  32 each  read data for the matching raddr.
REQ-007 wr_conflict  output  1  registered flag: previous cycle had both writes enabled to the same nonzero address.

Function
REQ-010 Storage SHALL be 32 x 32-bit registers; r0 SHALL read 0 at all times and SHALL ignore writes.
REQ-011 On posedge clk with reset low, weN=1 and waddrN!=0 SHALL write wdataN to register waddrN; write latency is one edge.
REQ-012 Both write ports SHALL commit in the same cycle when addresses differ.
REQ-013 Same nonzero address on both enabled ports: port 2 (younger instruction) SHALL win; port 1 data SHALL be discarded.
REQ-014 wr_conflict SHALL be set on the edge following a REQ-013 case and cleared on any edge without one; wr_conflict SHALL be 0 when either port's address is 0.
REQ-015 Reads SHALL be combinational from raddrN; all four read ports SHALL be independent and may address the same register.
REQ-016 weN=0 SHALL leave storage unchanged regardless of waddrN/wdataN values (X on disabled fields SHALL NOT propagate).
REQ-017 Reads of a register written this cycle SHALL return the old value unless RF_BYPASS_EN is defined (REQ-030).

Reset
REQ-020 While reset is high at posedge clk, all 32 registers SHALL be cleared to 0 and wr_conflict SHALL clear to 0; writes on that edge SHALL be ignored.
REQ-021 Reset asserted mid-stream SHALL take effect on the next edge only; the first post-reset edge with reset low SHALL accept writes normally.
REQ-022 After reset all rdataN SHALL read 0 for every address.

Configuration
REQ-030 With `RF_BYPASS_EN defined, rdataN SHALL return wdata of an enabled same-cycle write to raddrN (raddrN!=0); port 2 SHALL take priority over port 1, and either SHALL take priority over storage.
REQ-031 Without `RF_BYPASS_EN, rdataN SHALL return stored contents only; no forwarding logic SHALL be synthesised.
REQ-032 Bypass SHALL be suppressed while reset is high (rdataN from storage).

Structure
REQ-040 `WS_TO_RF_BUS_WD, bus field offsets and the register count (32) SHALL live in the shared define header beside the pipeline bus widths.
REQ-041 One sub-module rf_read_port (one raddr -> rdata with r0 masking and optional bypass mux) SHALL be instantiated four times; storage and write logic SHALL stay in regfile_2w4r.

Verification
REQ-050 Reset, then read all 32 addresses on all four ports -> every rdata = 0x00000000, wr_conflict = 0.
REQ-051 we1=1 waddr1=5 wdata1=0x12345678, we2=1 waddr2=6 wdata2=0xCAFEBABE; next cycle raddr1=5, raddr2=6 -> 0x12345678, 0xCAFEBABE.
REQ-052 Both ports write addr 7 (0x11111111 on port 1, 0x22222222 on port 2) -> r7 = 0x22222222 and wr_conflict = 1 for one cycle; next idle cycle -> wr_conflict = 0.
REQ-053 we1=1 waddr1=0 wdata1=0xFFFFFFFF -> rdata for raddr=0 stays 0 and wr_conflict stays 0 even if port 2 also targets 0.
REQ-054 With r9=0xAAAA0000 stored, same-cycle we2=1 waddr2=9 wdata2=0x0000BBBB with raddr3=9 -> rdata3 = 0x0000BBBB when `RF_BYPASS_EN is defined, 0xAAAA0000 without it; both builds read 0x0000BBBB next cycle.
REQ-055 Write r3=0x5 with reset held high on the same edge -> r3 reads 0 afterward; repeat the write with reset low -> r3 reads 0x5.

Source files
------------

// File: rtl/regfile_2w4r_pkg.sv
// Shared writeback-bus defines and register file types for regfile_2w4r.
// Optional build macro: RF_BYPASS_EN (same-cycle write-to-read forwarding).
`ifndef REGFILE_2W4R_DEFINES
`define REGFILE_2W4R_DEFINES
`define WS_TO_RF_BUS_WD   76
`define RF_NREGS          32
`define WS_RF_WE1_BIT     75
`define WS_RF_WADDR1_LSB  70
`define WS_RF_WDATA1_LSB  38
`define WS_RF_WE2_BIT     37
`define WS_RF_WADDR2_LSB  32
`define WS_RF_WDATA2_LSB  0
`endif

package regfile_2w4r_pkg;

  localparam int RF_NREGS = `RF_NREGS;
  localparam int RF_DW    = 32;
  localparam int RF_AW    = 5;
  localparam int WS_BUS_W = `WS_TO_RF_BUS_WD;

  // Field order mirrors the bus layout, MSB first (we1 sits at bit 75).
  typedef struct packed {
    logic             we1;
    logic [RF_AW-1:0] waddr1;
    logic [RF_DW-1:0] wdata1;
    logic             we2;
    logic [RF_AW-1:0] waddr2;
    logic [RF_DW-1:0] wdata2;
  } ws_to_rf_t;

  typedef logic [RF_NREGS-1:0][RF_DW-1:0] rf_array_t;

endpackage

// File: rtl/regfile_2w4r_read_port.sv
// rf_read_port: one combinational read port with r0 masking.
// With RF_BYPASS_EN defined, forwards same-cycle writes (port 2 over port 1).
module rf_read_port
  import regfile_2w4r_pkg::*;
(
  input  logic [RF_AW-1:0] i_raddr,
  input  rf_array_t        i_regs,
`ifdef RF_BYPASS_EN
  input  logic             i_reset,
  input  ws_to_rf_t        i_ws,
`endif
  output logic [RF_DW-1:0] o_rdata
);

  logic [RF_DW-1:0] w_stored;

  assign w_stored = (i_raddr == '0) ? '0 : i_regs[i_raddr];

`ifdef RF_BYPASS_EN
  // Forwarding is disabled during reset so reads reflect storage only.
  always_comb begin
    o_rdata = w_stored;
    if (!i_reset && (i_raddr != '0)) begin
      if (i_ws.we2 && (i_ws.waddr2 == i_raddr)) begin
        o_rdata = i_ws.wdata2;
      end else if (i_ws.we1 && (i_ws.waddr1 == i_raddr)) begin
        o_rdata = i_ws.wdata1;
      end
    end
  end
`else
  assign o_rdata = w_stored;
`endif

endmodule

// File: rtl/regfile_2w4r.sv
// regfile_2w4r: 32x32 register file, two write ports, four read ports.
// Optional build macro: RF_BYPASS_EN (forward same-cycle writes to reads).
module regfile_2w4r
  import regfile_2w4r_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic [`WS_TO_RF_BUS_WD-1:0] ws_to_rf_bus,
  input  logic [RF_AW-1:0]            raddr1,
  input  logic [RF_AW-1:0]            raddr2,
  input  logic [RF_AW-1:0]            raddr3,
  input  logic [RF_AW-1:0]            raddr4,
  output logic [RF_DW-1:0]            rdata1,
  output logic [RF_DW-1:0]            rdata2,
  output logic [RF_DW-1:0]            rdata3,
  output logic [RF_DW-1:0]            rdata4,
  output logic                        wr_conflict
);

  ws_to_rf_t w_ws;
  logic      w_wen1;
  logic      w_wen2;
  logic      w_conflict;
  rf_array_t r_regs;
  logic      r_wr_conflict;

  assign w_ws       = ws_to_rf_bus;
  assign w_wen1     = w_ws.we1 && (w_ws.waddr1 != '0);
  assign w_wen2     = w_ws.we2 && (w_ws.waddr2 != '0);
  assign w_conflict = w_wen1 && w_wen2 && (w_ws.waddr1 == w_ws.waddr2);

  // Port 2 is written last so it wins when both ports hit the same register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_regs        <= '0;
      r_wr_conflict <= 1'b0;
    end else begin
      if (w_wen1) begin
        r_regs[w_ws.waddr1] <= w_ws.wdata1;
      end
      if (w_wen2) begin
        r_regs[w_ws.waddr2] <= w_ws.wdata2;
      end
      r_wr_conflict <= w_conflict;
    end
  end

  assign wr_conflict = r_wr_conflict;

`ifdef RF_BYPASS_EN
  rf_read_port u_rd1 (.i_raddr(raddr1), .i_regs(r_regs), .i_reset(reset), .i_ws(w_ws), .o_rdata(rdata1));
  rf_read_port u_rd2 (.i_raddr(raddr2), .i_regs(r_regs), .i_reset(reset), .i_ws(w_ws), .o_rdata(rdata2));
  rf_read_port u_rd3 (.i_raddr(raddr3), .i_regs(r_regs), .i_reset(reset), .i_ws(w_ws), .o_rdata(rdata3));
  rf_read_port u_rd4 (.i_raddr(raddr4), .i_regs(r_regs), .i_reset(reset), .i_ws(w_ws), .o_rdata(rdata4));
`else
  rf_read_port u_rd1 (.i_raddr(raddr1), .i_regs(r_regs), .o_rdata(rdata1));
  rf_read_port u_rd2 (.i_raddr(raddr2), .i_regs(r_regs), .o_rdata(rdata2));
  rf_read_port u_rd3 (.i_raddr(raddr3), .i_regs(r_regs), .o_rdata(rdata3));
  rf_read_port u_rd4 (.i_raddr(raddr4), .i_regs(r_regs), .o_rdata(rdata4));
`endif

endmodule

// File: tb/tb_regfile_2w4r.sv
// Directed self-checking bench for regfile_2w4r with an expected-value queue.
// Honours RF_BYPASS_EN to pick the same-cycle read expectations.
module tb_regfile_2w4r;
  import regfile_2w4r_pkg::*;

  logic                clk = 1'b0;
  logic                reset;
  logic [WS_BUS_W-1:0] ws_to_rf_bus;
  logic [RF_AW-1:0]    raddr1, raddr2, raddr3, raddr4;
  logic [RF_DW-1:0]    rdata1, rdata2, rdata3, rdata4;
  logic                wr_conflict;

  int compareCount  = 0;
  int mismatchCount = 0;

  logic [31:0] expQ[$];
  string       tagQ[$];

  localparam logic [WS_BUS_W-1:0] IDLE = '0;

  regfile_2w4r dut (
    .clk(clk), .reset(reset), .ws_to_rf_bus(ws_to_rf_bus),
    .raddr1(raddr1), .raddr2(raddr2), .raddr3(raddr3), .raddr4(raddr4),
    .rdata1(rdata1), .rdata2(rdata2), .rdata3(rdata3), .rdata4(rdata4),
    .wr_conflict(wr_conflict)
  );

  always #5 clk = ~clk;

  // Packs a writeback request in bus order: we1, waddr1, wdata1, we2, waddr2, wdata2.
  function automatic logic [WS_BUS_W-1:0] mkBus(input logic we1, input logic [4:0] a1,
                                                input logic [31:0] d1, input logic we2,
                                                input logic [4:0] a2, input logic [31:0] d2);
    return {we1, a1, d1, we2, a2, d2};
  endfunction

  // Drives the write bus and all four read addresses in one step.
  task automatic applyStimulus(input logic [WS_BUS_W-1:0] bus, input logic [4:0] a1,
                               input logic [4:0] a2, input logic [4:0] a3, input logic [4:0] a4);
    ws_to_rf_bus = bus;
    raddr1 = a1;
    raddr2 = a2;
    raddr3 = a3;
    raddr4 = a4;
  endtask

  // Queues a value the DUT is expected to produce at the next observation.
  task automatic expect_val(input string tag, input logic [31:0] value);
    expQ.push_back(value);
    tagQ.push_back(tag);
  endtask

  // Pops the oldest expectation and compares it with what the DUT shows now.
  task automatic checkOutput(input logic [31:0] observed);
    logic [31:0] exp;
    string       tag;
    compareCount++;
    if (expQ.size() == 0) begin
      mismatchCount++;
      $display("[TB] FAIL scoreboard_empty observed=0x%08h expected=none", observed);
    end else begin
      exp = expQ.pop_front();
      tag = tagQ.pop_front();
      assert (observed === exp) else begin
        mismatchCount++;
        $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, exp);
      end
    end
  endtask

  // Moves to just after the next rising edge, where registered state is stable.
  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] byp9;
    logic [31:0] byp10;
`ifdef RF_BYPASS_EN
    byp9  = 32'h0000BBBB;
    byp10 = 32'h0000DDDD;
`else
    byp9  = 32'hAAAA0000;
    byp10 = 32'h00000000;
`endif

    // Reset for two edges with an idle bus.
    reset = 1'b1;
    applyStimulus(IDLE, 5'd0, 5'd0, 5'd0, 5'd0);
    stepEdge();
    stepEdge();
    reset = 1'b0;
    #1;

    // Every address on every port reads zero after reset.
    for (int a = 0; a < 32; a++) begin
      applyStimulus(IDLE, 5'(a), 5'(a), 5'(a), 5'(a));
      expect_val("rst_rd1", 32'h0); expect_val("rst_rd2", 32'h0);
      expect_val("rst_rd3", 32'h0); expect_val("rst_rd4", 32'h0);
      #1;
      checkOutput(rdata1); checkOutput(rdata2); checkOutput(rdata3); checkOutput(rdata4);
    end
    expect_val("rst_conflict", 32'h0);
    checkOutput({31'b0, wr_conflict});

    // Two different addresses commit on the same edge.
    applyStimulus(mkBus(1'b1, 5'd5, 32'h12345678, 1'b1, 5'd6, 32'hCAFEBABE), 5'd0, 5'd0, 5'd0, 5'd0);
    expect_val("dual_r5", 32'h12345678); expect_val("dual_r6", 32'hCAFEBABE);
    expect_val("dual_r5_p3", 32'h12345678); expect_val("dual_r6_p4", 32'hCAFEBABE);
    expect_val("dual_conflict", 32'h0);
    stepEdge();
    applyStimulus(IDLE, 5'd5, 5'd6, 5'd5, 5'd6);
    #1;
    checkOutput(rdata1); checkOutput(rdata2); checkOutput(rdata3); checkOutput(rdata4);
    checkOutput({31'b0, wr_conflict});

    // Same-address collision: port 2 wins and the conflict flag pulses once.
    applyStimulus(mkBus(1'b1, 5'd7, 32'h11111111, 1'b1, 5'd7, 32'h22222222), 5'd7, 5'd5, 5'd6, 5'd0);
    expect_val("coll_r7", 32'h22222222); expect_val("coll_conflict", 32'h1);
    stepEdge();
    applyStimulus(IDLE, 5'd7, 5'd5, 5'd6, 5'd0);
    #1;
    checkOutput(rdata1);
    checkOutput({31'b0, wr_conflict});
    expect_val("coll_clear", 32'h0);
    stepEdge();
    checkOutput({31'b0, wr_conflict});

    // Writes to r0 are dropped and never flag a conflict.
    applyStimulus(mkBus(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 32'h12121212), 5'd0, 5'd0, 5'd0, 5'd0);
    expect_val("r0_sameCycle", 32'h0);
    #1;
    checkOutput(rdata1);
    expect_val("r0_after", 32'h0); expect_val("r0_conflict", 32'h0);
    stepEdge();
    applyStimulus(IDLE, 5'd0, 5'd0, 5'd0, 5'd0);
    #1;
    checkOutput(rdata2);
    checkOutput({31'b0, wr_conflict});

    // Same-cycle read of a register being written, then the committed value.
    applyStimulus(mkBus(1'b1, 5'd9, 32'hAAAA0000, 1'b0, 5'd0, 32'h0), 5'd0, 5'd0, 5'd0, 5'd0);
    stepEdge();
    applyStimulus(mkBus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h0000BBBB), 5'd0, 5'd0, 5'd9, 5'd0);
    expect_val("byp_r9_same", byp9);
    #1;
    checkOutput(rdata3);
    expect_val("byp_r9_next", 32'h0000BBBB);
    stepEdge();
    applyStimulus(IDLE, 5'd0, 5'd0, 5'd9, 5'd0);
    #1;
    checkOutput(rdata3);

    // Both ports hit r10 in the same cycle: forwarded value must be port 2's.
    applyStimulus(mkBus(1'b1, 5'd10, 32'h0000CCCC, 1'b1, 5'd10, 32'h0000DDDD), 5'd0, 5'd0, 5'd0, 5'd10);
    expect_val("byp_prio_r10", byp10);
    #1;
    checkOutput(rdata4);
    stepEdge();

    // Disabled ports carrying X must not disturb storage or the flag.
    applyStimulus({1'b0, 5'bx, 32'bx, 1'b0, 5'bx, 32'bx}, 5'd5, 5'd6, 5'd7, 5'd10);
    expect_val("x_r5", 32'h12345678); expect_val("x_r6", 32'hCAFEBABE);
    expect_val("x_r7", 32'h22222222); expect_val("x_r10", 32'h0000DDDD);
    expect_val("x_conflict", 32'h0);
    stepEdge();
    #1;
    checkOutput(rdata1); checkOutput(rdata2); checkOutput(rdata3); checkOutput(rdata4);
    checkOutput({31'b0, wr_conflict});

    // Mid-stream reset: the write on the reset edge is lost and forwarding is off.
    reset = 1'b1;
    applyStimulus(mkBus(1'b1, 5'd3, 32'h00000005, 1'b1, 5'd5, 32'h00000077), 5'd3, 5'd5, 5'd0, 5'd0);
    expect_val("rstHi_r5_storage", 32'h12345678);
    #1;
    checkOutput(rdata2);
    expect_val("rstHi_r3", 32'h0); expect_val("rstHi_r5", 32'h0); expect_val("rstHi_conflict", 32'h0);
    stepEdge();
    reset = 1'b0;
    applyStimulus(IDLE, 5'd3, 5'd5, 5'd0, 5'd0);
    #1;
    checkOutput(rdata1); checkOutput(rdata2);
    checkOutput({31'b0, wr_conflict});

    // First edge with reset low accepts the same write.
    applyStimulus(mkBus(1'b1, 5'd3, 32'h00000005, 1'b0, 5'd0, 32'h0), 5'd0, 5'd0, 5'd0, 5'd0);
    expect_val("postRst_r3", 32'h00000005);
    stepEdge();
    applyStimulus(IDLE, 5'd3, 5'd0, 5'd0, 5'd0);
    #1;
    checkOutput(rdata1);

    if (expQ.size() != 0) begin
      compareCount++;
      mismatchCount++;
      $display("[TB] FAIL scoreboard_leftover observed=%0d expected=0", expQ.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
